// File: rtl/gray_pkg.sv
// Shared types and gray/binary helpers for the gray stream link.
// Helpers work on zero-extended words of any width up to 32.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_GOOD,
    STEP_BAD
  } step_t;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational gray-to-binary decode.
// Each binary bit is the XOR of all gray bits at or above it.
module gray2bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Consumer side of a gray-coded count link: decode, step check,
// lock tracking and a saturating step error counter.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gray_vld,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 err_clr,
  output logic                 bin_vld,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_CNT);

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_nxt;
  logic [WIDTH-1:0] prev_inc;
  logic [GW-1:0]    good_cnt;
  logic [GW-1:0]    good_nxt;
  logic [GW-1:0]    good_inc;
  state_t           state;
  state_t           state_nxt;
  step_t            cls;
  logic             fire;
  logic             err_sat;

  gray2bin_comb #(
    .WIDTH(WIDTH)
  ) u_dec (
    .gray(gray_in),
    .bin (dec)
  );

  assign prev_inc = prev + WIDTH'(1);
  assign good_inc = good_cnt + GW'(1);
  assign err_sat  = &err_cnt;

  // Classify the new decoded sample against the last accepted one.
  always_comb begin
    cls = STEP_BAD;
    unique case (1'b1)
      (dec == prev_inc): cls = STEP_GOOD;
      (dec == prev):     cls = STEP_HOLD;
      default:           cls = STEP_BAD;
    endcase
  end

  // Lock FSM next state; only advances on valid samples.
  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    good_nxt  = good_cnt;
    fire      = 1'b0;
    if (gray_vld) begin
      unique case (state)
        IDLE: begin
          state_nxt = ACQ;
          prev_nxt  = dec;
          good_nxt  = '0;
        end
        ACQ: begin
          if (cls == STEP_GOOD) begin
            prev_nxt = dec;
            good_nxt = good_inc;
            if (good_inc == LOCK_TGT) begin
              state_nxt = LOCKED;
            end
          end else if (cls == STEP_BAD) begin
            prev_nxt = dec;
            good_nxt = '0;
          end
        end
        LOCKED: begin
          if (cls == STEP_GOOD) begin
            prev_nxt = dec;
          end else if (cls == STEP_BAD) begin
            fire      = 1'b1;
            prev_nxt  = dec;
            good_nxt  = '0;
            state_nxt = ACQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state, reference sample and good-step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prev     <= '0;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prev     <= prev_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Output capture, aligned so a sample's results appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_vld  <= 1'b0;
      bin_out  <= '0;
      step_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      bin_vld  <= gray_vld;
      step_err <= fire;
      locked   <= (state_nxt == LOCKED);
      if (gray_vld) begin
        bin_out <= dec;
      end
    end
  end

  // Saturating error count; a clear that meets an error leaves one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= fire ? ERR_CNT_W'(1) : '0;
    end else if (fire && !err_sat) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder.
// A second instance with a 2-bit error counter covers saturation.
module tb_gray_stream_decoder;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gray_vld;
  logic [3:0] gray_in;
  logic       err_clr;
  logic       bin_vld;
  logic [3:0] bin_out;
  logic       step_err;
  logic       locked;
  logic [7:0] err_cnt;
  logic       bin_vld2;
  logic [3:0] bin_out2;
  logic       step_err2;
  logic       locked2;
  logic [1:0] err_cnt2;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  logic [3:0]  v;
  logic [31:0] g32;

  always #5 clk = ~clk;

  gray_stream_decoder #(
    .WIDTH(4), .LOCK_CNT(4), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .gray_vld(gray_vld), .gray_in(gray_in),
    .err_clr(err_clr),
    .bin_vld(bin_vld), .bin_out(bin_out),
    .step_err(step_err), .locked(locked),
    .err_cnt(err_cnt)
  );

  gray_stream_decoder #(
    .WIDTH(4), .LOCK_CNT(4), .ERR_CNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .gray_vld(gray_vld), .gray_in(gray_in),
    .err_clr(err_clr),
    .bin_vld(bin_vld2), .bin_out(bin_out2),
    .step_err(step_err2), .locked(locked2),
    .err_cnt(err_cnt2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic       vld,
    input logic [3:0] b,
    input logic       clr
  );
    @(negedge clk);
    g32      = bin2gray({28'd0, b});
    gray_vld = vld;
    gray_in  = g32[3:0];
    err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    gray_vld = 1'b0;
    gray_in  = '0;
    err_clr  = 1'b0;
    #12;
    chk("rst_bin_out", 32'(bin_out), 0);
    chk("rst_bin_vld", 32'(bin_vld), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: count 0..15, lock when bin_out reaches 4
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'(i), 1'b0);
      chk("t1_bin_out", 32'(bin_out), 32'(i));
      chk("t1_bin_vld", 32'(bin_vld), 1);
      chk("t1_locked", 32'(locked), (i >= 4) ? 1 : 0);
      chk("t1_step_err", 32'(step_err), 0);
    end

    // 2: wrap 14,15,0,1 while locked
    for (int i = 0; i < 14; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'd14, 1'b0);
    chk("t2_locked14", 32'(locked), 1);
    step(1'b1, 4'd15, 1'b0);
    chk("t2_bin15", 32'(bin_out), 15);
    step(1'b1, 4'd0, 1'b0);
    chk("t2_bin0", 32'(bin_out), 0);
    chk("t2_locked0", 32'(locked), 1);
    chk("t2_err0", 32'(step_err), 0);
    step(1'b1, 4'd1, 1'b0);
    chk("t2_locked1", 32'(locked), 1);
    chk("t2_err1", 32'(step_err), 0);

    // 3: locked at 6, jump to 8, relock at 12
    for (int i = 2; i <= 6; i++) step(1'b1, 4'(i), 1'b0);
    chk("t3_locked6", 32'(locked), 1);
    step(1'b1, 4'd8, 1'b0);
    chk("t3_step_err", 32'(step_err), 1);
    chk("t3_err_cnt", 32'(err_cnt), 1);
    chk("t3_unlocked", 32'(locked), 0);
    chk("t3_bin8", 32'(bin_out), 8);
    step(1'b1, 4'd9, 1'b0);
    chk("t3_err_pulse", 32'(step_err), 0);
    step(1'b1, 4'd10, 1'b0);
    step(1'b1, 4'd11, 1'b0);
    chk("t3_locked11", 32'(locked), 0);
    step(1'b1, 4'd12, 1'b0);
    chk("t3_relock", 32'(locked), 1);
    chk("t3_bin12", 32'(bin_out), 12);

    // 4: repeated 4 with valid gaps, then 5
    for (int i = 13; i <= 19; i++) step(1'b1, 4'(i), 1'b0);
    step(1'b1, 4'd4, 1'b0);
    chk("t4_first4_err", 32'(step_err), 0);
    step(1'b0, 4'd4, 1'b0);
    chk("t4_gap_vld", 32'(bin_vld), 0);
    chk("t4_gap_hold", 32'(bin_out), 4);
    step(1'b1, 4'd4, 1'b0);
    chk("t4_hold_vld", 32'(bin_vld), 1);
    chk("t4_hold_err", 32'(step_err), 0);
    step(1'b0, 4'd9, 1'b0);
    chk("t4_gap2_hold", 32'(bin_out), 4);
    step(1'b1, 4'd4, 1'b0);
    chk("t4_hold2_lock", 32'(locked), 1);
    step(1'b1, 4'd5, 1'b0);
    chk("t4_bin5", 32'(bin_out), 5);
    chk("t4_locked", 32'(locked), 1);
    chk("t4_err", 32'(step_err), 0);
    chk("t4_err_cnt", 32'(err_cnt), 1);

    // 5: clear, five error/relock rounds, saturation, clear on error
    step(1'b0, 4'd5, 1'b1);
    chk("t5_clr", 32'(err_cnt), 0);
    chk("t5_clr2", 32'(err_cnt2), 0);
    v = 4'd5;
    for (int k = 0; k < 5; k++) begin
      v = v + 4'd2;
      step(1'b1, v, 1'b0);
      chk("t5_step_err", 32'(step_err2), 1);
      chk("t5_err_cnt", 32'(err_cnt), 32'(k + 1));
      chk("t5_err_cnt2", 32'(err_cnt2), (k >= 2) ? 3 : 32'(k + 1));
      for (int j = 0; j < 4; j++) begin
        v = v + 4'd1;
        step(1'b1, v, 1'b0);
      end
      chk("t5_relock", 32'(locked2), 1);
    end
    v = v + 4'd2;
    step(1'b1, v, 1'b1);
    chk("t5_clr_err", 32'(err_cnt), 1);
    chk("t5_clr_err2", 32'(err_cnt2), 1);
    chk("t5_clr_pulse", 32'(step_err), 1);

    // 6: async reset mid-cycle while locked, then relock from scratch
    for (int j = 0; j < 4; j++) begin
      v = v + 4'd1;
      step(1'b1, v, 1'b0);
    end
    chk("t6_pre_lock", 32'(locked), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_locked", 32'(locked), 0);
    chk("t6_bin_out", 32'(bin_out), 0);
    chk("t6_bin_vld", 32'(bin_vld), 0);
    chk("t6_err_cnt", 32'(err_cnt), 0);
    chk("t6_step_err", 32'(step_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0);
    chk("t6_nolock4", 32'(locked), 0);
    step(1'b1, 4'd4, 1'b0);
    chk("t6_lock5", 32'(locked), 1);
    chk("t6_bin4", 32'(bin_out), 4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
